// File: rtl/hpc2_issue_ctrl.sv
// Issue sequencer for an HPC2 masked-AND gadget bank: admits an op only when
// operands, fresh randomness and capture-buffer credit are all present.
module hpc2_issue_ctrl #(
    parameter int LAT     = 2,
    parameter int CREDITS = 4,
    parameter int SCW     = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           rnd_valid,
    output logic           rnd_ready,
    output logic           issue_b,
    output logic           issue_a,
    output logic           out_valid,
    input  logic           buf_pop,
    output logic [3:0]     credits,
    output logic           busy,
    output logic [SCW-1:0] starve_cnt,
    input  logic           clr_stats
);

    localparam logic [3:0]     CR_MAX = 4'(CREDITS);
    localparam logic [SCW-1:0] SC_MAX = '1;

    logic [LAT-1:0] r_tok;
    logic [3:0]     r_credits;
    logic           r_issue_a;
    logic [SCW-1:0] r_starve;

    logic           w_has_cr;
    logic           w_go;
    logic [4:0]     w_cr_sum;
    logic [3:0]     w_cr_next;

    assign w_has_cr = (r_credits != 4'd0);
    assign w_go     = in_valid & rnd_valid & w_has_cr & ~rst;

    // Credit is reserved at issue; a pop against a full pool is dropped by the clamp.
    assign w_cr_sum  = {1'b0, r_credits} + 5'(buf_pop) - 5'(w_go);
    assign w_cr_next = (w_cr_sum > {1'b0, CR_MAX}) ? CR_MAX : w_cr_sum[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tok     <= '0;
            r_credits <= CR_MAX;
            r_issue_a <= 1'b0;
            r_starve  <= '0;
        end else begin
            r_tok     <= {r_tok[LAT-2:0], w_go};
            r_credits <= w_cr_next;
            r_issue_a <= w_go;
            if (clr_stats)
                r_starve <= '0;
            else if (in_valid & w_has_cr & ~rnd_valid & (r_starve != SC_MAX))
                r_starve <= r_starve + 1'b1;
        end
    end

    assign in_ready   = w_go;
    assign rnd_ready  = w_go;
    assign issue_b    = w_go;
    assign issue_a    = r_issue_a;
    assign out_valid  = r_tok[LAT-1];
    assign busy       = |r_tok;
    assign credits    = r_credits;
    assign starve_cnt = r_starve;

endmodule

// File: tb/tb_hpc2_issue_ctrl.sv
// Bench for hpc2_issue_ctrl: table vectors, hand sequences and random traffic
// checked against a cycle-history reference model.
module tb_hpc2_issue_ctrl;

    localparam int LAT = 2;
    localparam int CREDITS = 4;
    localparam int HMAX = 8000;

    logic clk = 1'b0;
    logic rst = 1'b1, in_valid = 1'b0, rnd_valid = 1'b0, buf_pop = 1'b0, clr_stats = 1'b0;
    logic in_ready, rnd_ready, issue_b, issue_a, out_valid, busy;
    logic [3:0]  credits;
    logic [15:0] starve_cnt;
    logic        in_ready2, rnd_ready2, issue_b2, issue_a2, out_valid2, busy2;
    logic [3:0]  credits2;
    logic [2:0]  starve2;

    always #5 clk = ~clk;

    hpc2_issue_ctrl #(.LAT(LAT), .CREDITS(CREDITS), .SCW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .issue_b(issue_b),
        .issue_a(issue_a), .out_valid(out_valid), .buf_pop(buf_pop),
        .credits(credits), .busy(busy), .starve_cnt(starve_cnt), .clr_stats(clr_stats));

    // Narrow counter copy so saturation is reachable quickly.
    hpc2_issue_ctrl #(.LAT(LAT), .CREDITS(CREDITS), .SCW(3)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready2), .issue_b(issue_b2),
        .issue_a(issue_a2), .out_valid(out_valid2), .buf_pop(buf_pop),
        .credits(credits2), .busy(busy2), .starve_cnt(starve2), .clr_stats(clr_stats));

    int checks = 0, failures = 0;
    int n = 0;
    int m_cr = CREDITS, m_sc = 0, m_sc2 = 0;
    bit go_h[HMAX];
    bit rst_h[HMAX];
    int n_issue = 0, n_ov = 0, min_cr = 99;
    bit overlap = 0;

    typedef struct {
        bit iv, rv, pop;
        bit ready, ov;
        int cr;
    } vec_t;
    vec_t tv[12];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, n, act, exp);
        end
    endtask

    // A token issued at cycle i survives to cycle c unless rst was high in [i, c-1].
    function automatic bit alive(int i, int c);
        if (i < 0 || !go_h[i]) return 0;
        for (int j = i; j < c; j++) if (rst_h[j]) return 0;
        return 1;
    endfunction

    task automatic step(bit iv, bit rv, bit pop, bit clr, bit r);
        bit e_go, e_busy;
        @(negedge clk);
        in_valid = iv; rnd_valid = rv; buf_pop = pop; clr_stats = clr; rst = r;
        #1;
        if (n >= HMAX) begin
            $display("FAIL history_overflow cycle=%0d actual=%0d expected<%0d", n, n, HMAX);
            failures++;
            $fatal(1, "history overflow");
        end
        e_go = iv & rv & (m_cr != 0) & !r;
        e_busy = 0;
        for (int i = n - LAT; i < n; i++) if (alive(i, n)) e_busy = 1;
        if (n > 0) begin
            chk("in_ready", int'(in_ready), int'(e_go));
            chk("rnd_ready", int'(rnd_ready), int'(e_go));
            chk("issue_b", int'(issue_b), int'(e_go));
            chk("issue_a", int'(issue_a), int'(go_h[n-1]));
            chk("out_valid", int'(out_valid), int'(alive(n - LAT, n)));
            chk("busy", int'(busy), int'(e_busy));
            chk("credits", int'(credits), m_cr);
            chk("starve_cnt", int'(starve_cnt), m_sc);
            chk("starve_cnt_sat", int'(starve2), m_sc2);
        end
        go_h[n] = e_go;
        rst_h[n] = r;
        if (issue_b) n_issue++;
        if (out_valid) n_ov++;
        if (issue_a && issue_b) overlap = 1;
        if (int'(credits) < min_cr) min_cr = int'(credits);
        if (r) begin
            m_cr = CREDITS; m_sc = 0; m_sc2 = 0;
        end else begin
            if (clr) begin
                m_sc = 0; m_sc2 = 0;
            end else if (iv && m_cr != 0 && !rv) begin
                if (m_sc < 65535) m_sc++;
                if (m_sc2 < 7) m_sc2++;
            end
            m_cr = m_cr - int'(e_go) + int'(pop);
            if (m_cr > CREDITS) m_cr = CREDITS;
        end
        n++;
    endtask

    initial begin
        // Credit exhaustion from a full, idle pool; pop at k=8 frees one issue at k=9.
        for (int k = 0; k < 12; k++) begin
            tv[k].iv = 1; tv[k].rv = 1; tv[k].pop = (k == 8);
        end
        tv[0].ready = 1; tv[0].cr = 4; tv[0].ov = 0;
        tv[1].ready = 1; tv[1].cr = 3; tv[1].ov = 0;
        tv[2].ready = 1; tv[2].cr = 2; tv[2].ov = 1;
        tv[3].ready = 1; tv[3].cr = 1; tv[3].ov = 1;
        tv[4].ready = 0; tv[4].cr = 0; tv[4].ov = 1;
        tv[5].ready = 0; tv[5].cr = 0; tv[5].ov = 1;
        tv[6].ready = 0; tv[6].cr = 0; tv[6].ov = 0;
        tv[7].ready = 0; tv[7].cr = 0; tv[7].ov = 0;
        tv[8].ready = 0; tv[8].cr = 0; tv[8].ov = 0;
        tv[9].ready = 1; tv[9].cr = 1; tv[9].ov = 0;
        tv[10].ready = 0; tv[10].cr = 0; tv[10].ov = 0;
        tv[11].ready = 0; tv[11].cr = 0; tv[11].ov = 1;

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Reset then idle
        for (int k = 0; k < 20; k++) begin
            step(0, k[0], 0, 0, 0);
            chk("idle_credits", int'(credits), 4);
            chk("idle_strobes", int'({issue_a, issue_b, out_valid, busy}), 0);
        end

        // Single op
        step(1, 1, 0, 0, 0);
        chk("single_issue_b", int'(issue_b), 1);
        step(0, 1, 0, 0, 0);
        chk("single_issue_a", int'(issue_a), 1);
        chk("single_credits", int'(credits), 3);
        step(0, 0, 0, 0, 0);
        chk("single_out_valid", int'(out_valid), 1);
        step(0, 0, 0, 0, 0);
        chk("single_ov_once", int'(out_valid), 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("single_credit_back", int'(credits), 4);

        // Starvation and clear, then saturation of the narrow counter
        step(0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("starve_five", int'(starve_cnt), 5);
        chk("starve_issue", int'(issue_b), 1);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("starve_clr", int'(starve_cnt), 0);
        for (int k = 0; k < 9; k++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("starve_nine", int'(starve_cnt), 9);
        chk("starve_sat", int'(starve2), 7);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("starve_clr_prio", int'(starve_cnt), 0);

        // Table-driven credit exhaustion
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 12; k++) begin
            step(tv[k].iv, tv[k].rv, tv[k].pop, 0, 0);
            chk("tbl_in_ready", int'(in_ready), int'(tv[k].ready));
            chk("tbl_credits", int'(credits), tv[k].cr);
            chk("tbl_out_valid", int'(out_valid), int'(tv[k].ov));
        end

        // Streaming at one issue per cycle
        step(0, 0, 0, 0, 1);
        n_issue = 0; min_cr = 99; overlap = 0;
        for (int k = 0; k < 100; k++) step(1, 1, (k >= LAT), 0, 0);
        chk("stream_issues", n_issue, 100);
        chk("stream_overlap", int'(overlap), 1);
        chk("stream_cr_nonzero", int'(min_cr > 0), 1);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0);
        chk("stream_drained", int'(credits), 4);

        // Reset mid-flight
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        n_ov = 0;
        step(0, 0, 0, 0, 0);
        chk("rst_credits", int'(credits), 4);
        chk("rst_busy", int'(busy), 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
        chk("rst_no_out_valid", n_ov, 0);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 99) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
